// File: rtl/gameplay_pkg.sv
// Shared gameplay constants: screen limits, requester indices and the
// draw scheduler state encoding.
package gameplay_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  localparam int ERASE = 0;
  localparam int BLOCK = 1;
  localparam int HUD   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_raster_counter.sv
// Raster walker for one rectangle. The cur_x/cur_y outputs show the pixel
// that would be emitted at the coming edge. While load is high they show the
// start corner directly, so the first pixel can go out on the grant edge.
module rect_raster_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic       hold,
  input  logic [7:0] start_x,
  input  logic [6:0] start_y,
  input  logic [4:0] start_w,
  input  logic [4:0] start_h,
  output logic [8:0] cur_x,
  output logic [7:0] cur_y,
  output logic       last,
  output logic       empty
);

  logic [8:0] org_x;
  logic [4:0] w_q;
  logic [4:0] h_q;
  logic [4:0] col;
  logic [4:0] row;
  logic [8:0] x_q;
  logic [7:0] y_q;

  logic [8:0] b_org;
  logic [4:0] b_w;
  logic [4:0] b_h;
  logic [4:0] b_col;
  logic [4:0] b_row;
  logic [8:0] b_x;
  logic [7:0] b_y;
  logic       adv;

  // Select the fresh start corner on load, otherwise the running position
  always_comb begin
    b_org = load ? {1'b0, start_x} : org_x;
    b_w   = load ? start_w : w_q;
    b_h   = load ? start_h : h_q;
    b_col = load ? 5'd0 : col;
    b_row = load ? 5'd0 : row;
    b_x   = load ? {1'b0, start_x} : x_q;
    b_y   = load ? {1'b0, start_y} : y_q;
  end

  assign adv   = step & ~hold;
  assign cur_x = b_x;
  assign cur_y = b_y;
  assign empty = (b_w == 5'd0) || (b_h == 5'd0);
  assign last  = (b_col == (b_w - 5'd1)) && (b_row == (b_h - 5'd1));

  // Latch the rectangle on load; advance x first, wrapping into the next row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      org_x <= '0;
      w_q   <= '0;
      h_q   <= '0;
      col   <= '0;
      row   <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      if (load) begin
        org_x <= b_org;
        w_q   <= b_w;
        h_q   <= b_h;
      end
      if (adv) begin
        if (b_col == (b_w - 5'd1)) begin
          col <= 5'd0;
          x_q <= b_org;
          row <= b_row + 5'd1;
          y_q <= b_y + 8'd1;
        end else begin
          col <= b_col + 5'd1;
          x_q <= b_x + 9'd1;
          row <= b_row;
          y_q <= b_y;
        end
      end else if (load) begin
        col <= b_col;
        row <= b_row;
        x_q <= b_x;
        y_q <= b_y;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Fixed-priority rectangle fill scheduler: grants one requester at a time
// and rasterises its rectangle onto the VGA write port, one pixel per
// non-held cycle, clipping pixels that fall off the screen.
module draw_scheduler
  import gameplay_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] rect_x,
  input  logic [7*N_REQ-1:0] rect_y,
  input  logic [5*N_REQ-1:0] rect_w,
  input  logic [5*N_REQ-1:0] rect_h,
  input  logic [3*N_REQ-1:0] rect_colour,
  input  logic               hold,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               plot,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour
);

  localparam logic [8:0] X_LIM = 9'(SCR_W);
  localparam logic [7:0] Y_LIM = 8'(SCR_H);

  state_t state, state_nxt;

  logic [N_REQ-1:0] win;
  logic [N_REQ-1:0] sel;
  logic [7:0]       win_x;
  logic [6:0]       win_y;
  logic [4:0]       win_w;
  logic [4:0]       win_h;
  logic [2:0]       win_colour;
  logic [2:0]       colour_q;
  logic             any_req;
  logic             load;
  logic             slot;
  logic             fin;
  logic [8:0]       cur_x;
  logic [7:0]       cur_y;
  logic             last;
  logic             empty;
  logic             on_screen;

  // Lowest-index requester wins; scan from the top so index 0 overrides
  always_comb begin
    win        = '0;
    win_x      = '0;
    win_y      = '0;
    win_w      = '0;
    win_h      = '0;
    win_colour = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win        = '0;
        win[i]     = 1'b1;
        win_x      = rect_x[i*8 +: 8];
        win_y      = rect_y[i*7 +: 7];
        win_w      = rect_w[i*5 +: 5];
        win_h      = rect_h[i*5 +: 5];
        win_colour = rect_colour[i*3 +: 3];
      end
    end
  end

  assign any_req = |req;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; slot marks an edge at which a pixel may be emitted
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    slot      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          slot      = 1'b1;
          state_nxt = PLOT;
        end
      end
      PLOT: begin
        if (fin) state_nxt = DONE;
        else     slot      = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  rect_raster_counter u_raster (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (slot),
    .hold    (hold),
    .start_x (win_x),
    .start_y (win_y),
    .start_w (win_w),
    .start_h (win_h),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .last    (last),
    .empty   (empty)
  );

  assign on_screen = (cur_x < X_LIM) && (cur_y < Y_LIM);

  // Latch the winner and register the pixel strobe; fin flags the final PLOT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= '0;
      colour_q   <= '0;
      fin        <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      if (load) begin
        sel      <= win;
        colour_q <= win_colour;
      end
      if (slot && !hold) begin
        plot       <= !empty && on_screen;
        vga_x      <= cur_x[7:0];
        vga_y      <= cur_y[6:0];
        vga_colour <= load ? win_colour : colour_q;
        fin        <= last || empty;
      end else begin
        plot <= 1'b0;
        if (state == DONE) fin <= 1'b0;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign grant = (state != IDLE) ? sel : '0;
  assign done  = (state == DONE) ? sel : '0;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: expected pixels are queued as each
// request is driven and popped as the DUT strobes plot.
module tb_draw_scheduler;

  localparam int SW = 160;
  localparam int SH = 120;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } pix_t;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] rect_x;
  logic [20:0] rect_y;
  logic [14:0] rect_w;
  logic [14:0] rect_h;
  logic [8:0]  rect_colour;
  logic        hold;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  pix_t q[$];
  int   checks;
  int   errors;
  int   cyc;
  logic [2:0] d;

  draw_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .hold        (hold),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .plot        (plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_vga_x"}, int'(vga_x), 0);
    chk({tag, "_vga_y"}, int'(vga_y), 0);
    chk({tag, "_colour"}, int'(vga_colour), 0);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic setr(input int i, input int x, input int y, input int w,
                      input int h, input int c);
    rect_x[i*8 +: 8]      = 8'(x);
    rect_y[i*7 +: 7]      = 7'(y);
    rect_w[i*5 +: 5]      = 5'(w);
    rect_h[i*5 +: 5]      = 5'(h);
    rect_colour[i*3 +: 3] = 3'(c);
  endtask

  // Queue on-screen pixels in raster order; cyc0 < 0 disables cycle checks
  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input int c, input int cyc0);
    pix_t p;
    for (int r = 0; r < h; r++) begin
      for (int cl = 0; cl < w; cl++) begin
        if ((x + cl) < SW && (y + r) < SH) begin
          p.x   = x + cl;
          p.y   = y + r;
          p.c   = c;
          p.cyc = (cyc0 < 0) ? -1 : cyc0 + r * w + cl;
          q.push_back(p);
        end
      end
    end
  endtask

  // Watch the DUT cycle by cycle until a done pulse, an abort or the budget.
  // Cycle 1 is the cycle after the edge at which the task is entered.
  task automatic serve(input int budget, input int hs, input int hl,
                       input int abort_at, output int cycles,
                       output logic [2:0] dseen);
    pix_t p;
    int   to;
    dseen  = '0;
    cycles = 0;
    to     = 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      cycles = k;
      if (plot) begin
        if (q.size() == 0) begin
          chk("extra_pixel", int'(plot), 0);
        end else begin
          p = q.pop_front();
          chk("pix_x", int'(vga_x), p.x);
          chk("pix_y", int'(vga_y), p.y);
          chk("pix_colour", int'(vga_colour), p.c);
          if (p.cyc >= 0) chk("pix_cycle", k, p.cyc);
        end
      end
      if (hl > 0 && k > hs && k <= hs + hl) chk("hold_plot", int'(plot), 0);
      if (busy) chk("grant_onehot", int'($onehot(grant)), 1);
      hold = (hl > 0 && k >= hs && k < hs + hl);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk_idle_outputs("abort");
        #2;
        reset = 1'b0;
        to = 0;
        break;
      end
      if (|done) begin
        dseen = done;
        req   = req & ~done;
        to    = 0;
        break;
      end
    end
    hold = 1'b0;
    chk("serve_bound", to, 0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    req         = '0;
    hold        = 1'b0;
    rect_x      = '0;
    rect_y      = '0;
    rect_w      = '0;
    rect_h      = '0;
    rect_colour = '0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic 2x2 block draw
    @(posedge clk); #1;
    setr(1, 10, 20, 2, 2, 5);
    req[1] = 1'b1;
    push_rect(10, 20, 2, 2, 5, 1);
    @(posedge clk);
    serve(20, 0, 0, 0, cyc, d);
    chk("s1_done", int'(d), 2);
    chk("s1_cycles", cyc, 5);
    chk("s1_queue", q.size(), 0);

    // Three simultaneous requests served lowest index first
    @(posedge clk); #1;
    setr(0, 0, 0, 1, 1, 1);
    setr(1, 5, 5, 2, 1, 2);
    setr(2, 30, 40, 1, 2, 3);
    push_rect(0, 0, 1, 1, 1, -1);
    push_rect(5, 5, 2, 1, 2, -1);
    push_rect(30, 40, 1, 2, 3, -1);
    req = 3'b111;
    @(posedge clk);
    serve(20, 0, 0, 0, cyc, d);
    chk("s2_first", int'(d), 1);
    serve(20, 0, 0, 0, cyc, d);
    chk("s2_second", int'(d), 2);
    serve(20, 0, 0, 0, cyc, d);
    chk("s2_third", int'(d), 4);
    chk("s2_queue", q.size(), 0);

    // Rectangle straddling the bottom-right corner
    @(posedge clk); #1;
    setr(0, 158, 119, 4, 2, 6);
    req[0] = 1'b1;
    push_rect(158, 119, 4, 2, 6, 1);
    @(posedge clk);
    serve(30, 0, 0, 0, cyc, d);
    chk("s3_done", int'(d), 1);
    chk("s3_cycles", cyc, 9);
    chk("s3_queue", q.size(), 0);

    // Hold for three cycles mid-rectangle; inputs scrambled after the grant
    @(posedge clk); #1;
    setr(2, 50, 60, 3, 2, 7);
    req[2] = 1'b1;
    push_rect(50, 60, 3, 2, 7, -1);
    @(posedge clk); #1;
    setr(2, 0, 0, 31, 31, 0);
    serve(40, 2, 3, 0, cyc, d);
    chk("s4_done", int'(d), 4);
    chk("s4_cycles", cyc, 10);
    chk("s4_queue", q.size(), 0);

    // Zero-width request
    @(posedge clk); #1;
    setr(0, 1, 1, 0, 3, 2);
    req[0] = 1'b1;
    @(posedge clk);
    serve(20, 0, 0, 0, cyc, d);
    chk("s5_done", int'(d), 1);
    chk("s5_cycles", cyc, 2);

    // Reset during the third pixel, then a clean restart
    @(posedge clk); #1;
    setr(1, 20, 30, 4, 1, 4);
    req[1] = 1'b1;
    push_rect(20, 30, 4, 1, 4, 1);
    @(posedge clk);
    serve(20, 0, 0, 3, cyc, d);
    chk("s6_no_done", int'(d), 0);
    chk("s6_abort_cycle", cyc, 3);
    chk("s6_left", q.size(), 1);
    q.delete();
    push_rect(20, 30, 4, 1, 4, 1);
    serve(20, 0, 0, 0, cyc, d);
    chk("s6_done", int'(d), 2);
    chk("s6_cycles", cyc, 5);
    chk("s6_queue", q.size(), 0);

    @(negedge clk);
    chk("end_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
